cascade_controller: RTL and testbench

//   Synchronous, parametrised cascade manager for the PIC. Generalises the combinational CAS

---
 rtl/cascade_controller.sv | 163 ++++++++++++++++
 tb/tb_cascade_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cascade_controller.sv
// Cascade manager for the PIC: tracks the INTA pulse train,
// drives CAS as master, decodes CAS as slave, gates the vector.
module cascade_controller #(
    parameter int NUM_IR  = 8,
    parameter int CAS_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sp_en,
    input  logic              mode_8080,
    input  logic [NUM_IR-1:0] icw3,
    input  logic [NUM_IR-1:0] isr,
    input  logic              inta_n,
    input  logic [CAS_W-1:0]  cas_in,
    output logic [CAS_W-1:0]  cas_out,
    output logic              cas_oe,
    output logic              slave_sel,
    output logic              vec_en,
    output logic              seq_done,
    output logic              seq_abort
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, P1, G1, P2, G2, P3
    } state_t;

    state_t           state, state_d;
    logic             sync1, inta_s, inta_s_d;
    logic             fall, rise, tmo;
    logic [TW-1:0]    cnt, cnt_d;
    logic             sp_lat, mode_lat, cascaded;
    logic             sp_d, mode_d, casc_d;
    logic [CAS_W-1:0] id_lat, id_c, id_d;
    logic             sel_d, vec_d, oe_d, done_d, abort_d;
    logic [CAS_W-1:0] cas_d;

    assign fall = inta_s_d & ~inta_s;
    assign rise = ~inta_s_d & inta_s;
    assign tmo  = (cnt == TW'(TIMEOUT - 1));

    // Bring the asynchronous acknowledge into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            inta_s   <= 1'b1;
            inta_s_d <= 1'b1;
        end else begin
            sync1    <= inta_n;
            inta_s   <= sync1;
            inta_s_d <= inta_s;
        end
    end

    // Master id: lowest in-service bit, or the spurious id when none.
    always_comb begin
        id_c = CAS_W'(NUM_IR - 1);
        if (sp_en) begin
            for (int i = NUM_IR - 1; i >= 0; i--) begin
                if (isr[i]) id_c = CAS_W'(i);
            end
        end else begin
            id_c = icw3[CAS_W-1:0];
        end
    end

    // Next state, latches and registered output values.
    always_comb begin
        state_d = state;
        abort_d = 1'b0;
        done_d  = 1'b0;
        sp_d    = sp_lat;
        mode_d  = mode_lat;
        id_d    = id_lat;
        casc_d  = cascaded;
        sel_d   = slave_sel;
        if (state != IDLE && sp_en != sp_lat) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            unique case (state)
                IDLE: if (fall) begin
                    state_d = P1;
                    sp_d    = sp_en;
                    mode_d  = mode_8080;
                    id_d    = id_c;
                    casc_d  = sp_en & (|isr) & icw3[id_c];
                end
                P1: if (rise) begin
                    state_d = G1;
                    sel_d   = ~sp_lat & (cas_in == id_lat);
                end
                G1: if (fall) begin
                    state_d = P2;
                end else if (tmo) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
                P2: if (rise) begin
                    if (mode_lat) begin
                        state_d = G2;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                G2: if (fall) begin
                    state_d = P3;
                end else if (tmo) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end
                P3: if (rise) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) sel_d = 1'b0;
        oe_d  = (state_d != IDLE) & sp_d;
        cas_d = oe_d ? id_d : '0;
        vec_d = (state_d == P2 || state_d == P3) &
                (sp_d ? ~casc_d : sel_d);
        cnt_d = '0;
        if ((state_d == G1 || state_d == G2) && state_d == state)
            cnt_d = cnt + TW'(1);
    end

    // State, sequence latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sp_lat    <= 1'b0;
            mode_lat  <= 1'b0;
            id_lat    <= '0;
            cascaded  <= 1'b0;
            cas_out   <= '0;
            cas_oe    <= 1'b0;
            slave_sel <= 1'b0;
            vec_en    <= 1'b0;
            seq_done  <= 1'b0;
            seq_abort <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sp_lat    <= sp_d;
            mode_lat  <= mode_d;
            id_lat    <= id_d;
            cascaded  <= casc_d;
            cas_out   <= cas_d;
            cas_oe    <= oe_d;
            slave_sel <= sel_d;
            vec_en    <= vec_d;
            seq_done  <= done_d;
            seq_abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_cascade_controller.sv
// Randomised bench for cascade_controller against a
// sequence-level model of the INTA cascade protocol.
module tb_cascade_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sp_en, mode_8080;
    logic [7:0] icw3, isr;
    logic       inta_n;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe, slave_sel, vec_en, seq_done, seq_abort;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int abort_total = 0;

    cascade_controller #(.NUM_IR(8), .CAS_W(3), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .sp_en(sp_en),
        .mode_8080(mode_8080), .icw3(icw3), .isr(isr),
        .inta_n(inta_n), .cas_in(cas_in), .cas_out(cas_out),
        .cas_oe(cas_oe), .slave_sel(slave_sel), .vec_en(vec_en),
        .seq_done(seq_done), .seq_abort(seq_abort)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle strobes.
    always @(negedge clk) begin
        if (seq_done)  done_total  <= done_total + 1;
        if (seq_abort) abort_total <= abort_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".oe"}, cas_oe, 0);
        chk({tag, ".cas"}, cas_out, 0);
        chk({tag, ".sel"}, slave_sel, 0);
        chk({tag, ".vec"}, vec_en, 0);
    endtask

    // One complete acknowledge sequence against the protocol model.
    task automatic run_seq(input bit m, input bit m8, input logic [7:0] i,
                           input logic [7:0] c, input logic [2:0] ci);
        logic [7:0] lsb;
        int eid, w, d0;
        bit ecasc, esel, evec;
        sp_en = m; mode_8080 = m8; isr = i; icw3 = c; cas_in = ci;
        cyc(2);
        lsb   = i & (~i + 8'd1);
        eid   = (i == 0) ? 7 : $clog2(lsb);
        ecasc = (i != 0) && c[eid];
        esel  = !m && (ci == c[2:0]);
        evec  = m ? !ecasc : esel;
        d0    = done_total;
        w = $urandom_range(5, 9);
        inta_n = 1'b0; cyc(w);
        chk("p1.oe", cas_oe, m);
        chk("p1.cas", cas_out, m ? eid : 0);
        chk("p1.vec", vec_en, 0);
        isr = 8'($urandom);
        inta_n = 1'b1; cyc(w);
        chk("g1.sel", slave_sel, esel);
        chk("g1.vec", vec_en, 0);
        inta_n = 1'b0; cyc(w);
        chk("p2.vec", vec_en, evec);
        chk("p2.cas", cas_out, m ? eid : 0);
        if (m8) begin
            inta_n = 1'b1; cyc(w);
            chk("g2.vec", vec_en, 0);
            chk("g2.done", done_total - d0, 0);
            inta_n = 1'b0; cyc(w);
            chk("p3.vec", vec_en, evec);
        end
        inta_n = 1'b1; cyc(8);
        chk("end.done", done_total - d0, 1);
        idle_chk("end");
    endtask

    initial begin
        int a0, d0;
        rst_n = 1'b0; inta_n = 1'b1; sp_en = 1'b1; mode_8080 = 1'b0;
        isr = '0; icw3 = '0; cas_in = '0;
        cyc(3);
        idle_chk("rst");
        chk("rst.done", seq_done, 0);
        chk("rst.abort", seq_abort, 0);
        rst_n = 1'b1;
        cyc(3);

        run_seq(1, 0, 8'h04, 8'h00, 3'd0);
        run_seq(1, 0, 8'h28, 8'h08, 3'd0);
        run_seq(0, 0, 8'h00, 8'h05, 3'd5);
        run_seq(0, 0, 8'h00, 8'h05, 3'd4);
        run_seq(1, 1, 8'h10, 8'h00, 3'd0);
        run_seq(1, 0, 8'h00, 8'hff, 3'd0);
        run_seq(0, 1, 8'h00, 8'h03, 3'd3);

        for (int k = 0; k < 24; k++)
            run_seq($urandom_range(0, 1), $urandom_range(0, 1),
                    8'($urandom), 8'($urandom), 3'($urandom));

        // Gap longer than the timeout.
        sp_en = 1'b1; mode_8080 = 1'b0; isr = 8'h01; icw3 = 8'h00;
        a0 = abort_total; d0 = done_total;
        inta_n = 1'b0; cyc(6);
        inta_n = 1'b1; cyc(80);
        chk("tmo.abort", abort_total - a0, 1);
        chk("tmo.done", done_total - d0, 0);
        idle_chk("tmo");
        run_seq(1, 0, 8'h02, 8'h00, 3'd0);

        // Role change in the middle of a sequence.
        sp_en = 1'b1; isr = 8'h40; icw3 = 8'h00;
        a0 = abort_total;
        inta_n = 1'b0; cyc(6);
        inta_n = 1'b1; cyc(6);
        sp_en = 1'b0; cyc(4);
        chk("sp.abort", abort_total - a0, 1);
        idle_chk("sp");
        run_seq(1, 0, 8'h80, 8'h00, 3'd0);

        // Asynchronous reset while the vector is being driven.
        sp_en = 1'b1; isr = 8'h01; icw3 = 8'h00; mode_8080 = 1'b0;
        inta_n = 1'b0; cyc(6);
        inta_n = 1'b1; cyc(6);
        inta_n = 1'b0; cyc(6);
        chk("ar.vec_before", vec_en, 1);
        #3 rst_n = 1'b0;
        #1 idle_chk("ar");
        inta_n = 1'b1; cyc(3);
        rst_n = 1'b1; cyc(10);
        idle_chk("ar.rel");
        run_seq(1, 0, 8'h04, 8'h00, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
